// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the buffered system bus arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } arb_state_t;

  localparam int DEF_NREQ       = 3;
  localparam int DEF_TURNAROUND = 1;
  localparam int DEF_MAXHOLD    = 16;

  // Requester slots on the default three-master bus.
  localparam int REQ_CPU  = 0;
  localparam int REQ_DSP  = 1;
  localparam int REQ_BLIT = 2;

endpackage

// File: rtl/bus_buffer_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping NREQ-1 -> 0.
// Latency: combinational.
// Backpressure: none; valid low when no request is set.
//
// Ports:
//   req   in  NREQ          request vector
//   ptr   in  $clog2(NREQ)  index where the search starts (must be < NREQ)
//   pick  out NREQ          one-hot selected request
//   valid out 1             any request set
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         pick,
  output logic                    valid
);

  localparam int IW = $clog2(NREQ);
  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int SW = IW + 1;
  localparam logic [SW-1:0] N_S = SW'(NREQ);

  logic [SW-1:0] pos;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= N_S) pos = pos - N_S;
      if (!valid && req[pos[IW-1:0]]) begin
        pick[pos[IW-1:0]] = 1'b1;
        valid             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_buffer_arbiter.sv
// Round-robin owner of the buffered system bus; one buffer enable per requester.
// Latency: grant one edge after a pick; TURNAROUND idle cycles between owners.
// Backpressure: owner is preempted after MAXHOLD cycles if others wait, unless LOCK.
//
// Ports:
//   CLK    in  1             system clock, rising edge
//   RESETL in  1             asynchronous active-low reset
//   REQ    in  NREQ          level request per requester
//   LOCK   in  1             current owner forbids preemption
//   GNT    out NREQ          one-hot registered grant
//   BUFEN  out NREQ          bus-buffer enables, same register as GNT
//   OWNER  out $clog2(NREQ)  encoded owner index, 0 when idle
//   BUSY   out 1             bus owned
module bus_buffer_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int MAXHOLD    = DEF_MAXHOLD
) (
  input  logic                    CLK,
  input  logic                    RESETL,
  input  logic [NREQ-1:0]         REQ,
  input  logic                    LOCK,
  output logic [NREQ-1:0]         GNT,
  output logic [NREQ-1:0]         BUFEN,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    BUSY
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAXHOLD);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [1:0]    TURN_LAST = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;
  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [1:0]      turn_q, turn_d;
  // Search start for the next pick: one past the last owner, 0 after reset.
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NREQ-1:0] pick;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic            owner_req;
  logic            others_req;
  logic            preempt;
  logic            do_pick;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (REQ),
    .ptr   (rr_ptr_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Encoders: pick for the pointer update, the grant register for OWNER.
  always_comb begin
    pick_idx = '0;
    OWNER    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick[k])  pick_idx = IW'(k);
      if (gnt_q[k]) OWNER    = IW'(k);
    end
  end

  assign owner_req  = |(REQ & gnt_q);
  assign others_req = |(REQ & ~gnt_q);
  assign preempt    = (hold_q == HOLD_MAX) && others_req && !LOCK;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    hold_d   = hold_q;
    turn_d   = turn_q;
    rr_ptr_d = rr_ptr_q;
    do_pick  = 1'b0;

    case (state_q)
      ST_IDLE: do_pick = 1'b1;

      ST_OWN: begin
        if (!owner_req || preempt) begin
          gnt_d  = '0;
          hold_d = '0;
          if (TURNAROUND > 0) begin
            state_d = ST_TURN;
            turn_d  = TURN_LAST;
          end else begin
            // Zero gap: hand straight to the next requester in the same edge.
            do_pick = 1'b1;
          end
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLD_ONE;
        end
      end

      ST_TURN: begin
        // Pick uses REQ as seen in the final gap cycle, not at release.
        if (turn_q == 2'd0) do_pick = 1'b1;
        else                turn_d  = turn_q - 2'd1;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    if (do_pick) begin
      if (pick_vld) begin
        state_d  = ST_OWN;
        gnt_d    = pick;
        hold_d   = HOLD_ONE;
        rr_ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_ONE;
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETL) begin
    if (!RESETL) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      hold_q   <= '0;
      turn_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      hold_q   <= hold_d;
      turn_q   <= turn_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign GNT   = gnt_q;
  assign BUFEN = gnt_q;
  assign BUSY  = |gnt_q;

endmodule

// File: tb/tb_bus_buffer_arbiter.sv
// Bench for bus_buffer_arbiter: three instances (gap 1, gap 0, gap 2).
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_bus_buffer_arbiter;
  import bus_arb_pkg::*;

  localparam int NI = 3;

  logic                 CLK;
  logic                 RESETL;
  logic [NI-1:0][2:0]   req;
  logic [NI-1:0]        lock;
  logic [NI-1:0][2:0]   gnt;
  logic [NI-1:0][2:0]   bufen;
  logic [NI-1:0][1:0]   owner;
  logic [NI-1:0]        busy;

  int tests = 0;
  int fails = 0;

  // Model configuration per instance: turnaround gap and max hold.
  int ta_m [NI] = '{1, 0, 2};
  int mh_m [NI] = '{4, 4, 3};

  // Model state: current owner (-1 none), cycles owned, gap cycles left, last owner (-1 none).
  int m_owner [NI];
  int m_held  [NI];
  int m_gap   [NI];
  int m_last  [NI];

  typedef struct {
    logic       rstn;
    logic [2:0] r;
    logic       l;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  bus_buffer_arbiter #(.NREQ(3), .TURNAROUND(1), .MAXHOLD(4)) dut_ta1 (
    .CLK(CLK), .RESETL(RESETL), .REQ(req[0]), .LOCK(lock[0]),
    .GNT(gnt[0]), .BUFEN(bufen[0]), .OWNER(owner[0]), .BUSY(busy[0]));

  bus_buffer_arbiter #(.NREQ(3), .TURNAROUND(0), .MAXHOLD(4)) dut_ta0 (
    .CLK(CLK), .RESETL(RESETL), .REQ(req[1]), .LOCK(lock[1]),
    .GNT(gnt[1]), .BUFEN(bufen[1]), .OWNER(owner[1]), .BUSY(busy[1]));

  bus_buffer_arbiter #(.NREQ(3), .TURNAROUND(2), .MAXHOLD(3)) dut_ta2 (
    .CLK(CLK), .RESETL(RESETL), .REQ(req[2]), .LOCK(lock[2]),
    .GNT(gnt[2]), .BUFEN(bufen[2]), .OWNER(owner[2]), .BUSY(busy[2]));

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input int i, input logic [2:0] eg, input string tag);
    int eo;
    eo = 0;
    for (int k = 0; k < 3; k++) if (eg[k]) eo = k;
    chk($sformatf("%s[%0d] gnt", tag, i),   int'(gnt[i]),   int'(eg));
    chk($sformatf("%s[%0d] bufen", tag, i), int'(bufen[i]), int'(eg));
    chk($sformatf("%s[%0d] owner", tag, i), int'(owner[i]), eo);
    chk($sformatf("%s[%0d] busy", tag, i),  int'(busy[i]),  int'(|eg));
  endtask

  function automatic void add(input logic rstn, input logic [2:0] r, input logic l,
                              input logic [2:0] exp, input int n);
    vec_t v;
    v.rstn = rstn; v.r = r; v.l = l; v.exp = exp;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      m_owner[i] = -1; m_held[i] = 0; m_gap[i] = 0; m_last[i] = -1;
    end
  endfunction

  // Grant the first requester after the last owner, wrapping around.
  function automatic void model_grant(input int i, input logic [2:0] r);
    int idx;
    for (int k = 0; k < 3; k++) begin
      idx = (m_last[i] + 1 + k) % 3;
      if (m_owner[i] < 0 && r[idx]) begin
        m_owner[i] = idx; m_held[i] = 1; m_last[i] = idx;
      end
    end
  endfunction

  // Advance instance i by one clock edge given the inputs seen before it.
  function automatic void model_step(input int i, input logic [2:0] r, input logic l);
    logic [2:0] ob;
    logic       rel;
    if (m_owner[i] >= 0) begin
      ob = '0;
      ob[m_owner[i]] = 1'b1;
      rel = !r[m_owner[i]] || (m_held[i] == mh_m[i] && |(r & ~ob) && !l);
      if (rel) begin
        m_owner[i] = -1; m_held[i] = 0;
        if (ta_m[i] > 0) m_gap[i] = ta_m[i];
        else model_grant(i, r);
      end else if (m_held[i] < mh_m[i]) begin
        m_held[i]++;
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
      if (m_gap[i] == 0) model_grant(i, r);
    end else begin
      model_grant(i, r);
    end
  endfunction

  function automatic logic [2:0] model_gnt(input int i);
    logic [2:0] e;
    e = '0;
    if (m_owner[i] >= 0) e[m_owner[i]] = 1'b1;
    return e;
  endfunction

  // Called at a falling edge; leaves RESETL high at the next falling edge.
  task automatic do_reset();
    RESETL = 1'b0;
    req    = '0;
    lock   = '0;
    @(negedge CLK);
    RESETL = 1'b1;
  endtask

  initial begin
    RESETL = 1'b0;
    req    = '0;
    lock   = '0;

    // Vectors for the gap-1 instance: idle, single request, round-robin.
    add(1'b0, 3'b000, 1'b0, 3'b000, 1);
    add(1'b1, 3'b000, 1'b0, 3'b000, 10);
    add(1'b1, 3'b010, 1'b0, 3'b010, 5);
    add(1'b1, 3'b000, 1'b0, 3'b000, 3);
    add(1'b0, 3'b000, 1'b0, 3'b000, 1);
    add(1'b1, 3'b111, 1'b0, 3'b001, 4);
    add(1'b1, 3'b111, 1'b0, 3'b000, 1);
    add(1'b1, 3'b111, 1'b0, 3'b010, 4);
    add(1'b1, 3'b111, 1'b0, 3'b000, 1);
    add(1'b1, 3'b111, 1'b0, 3'b100, 4);
    add(1'b1, 3'b111, 1'b0, 3'b000, 1);
    add(1'b1, 3'b111, 1'b0, 3'b001, 1);
    add(1'b1, 3'b000, 1'b0, 3'b000, 1);

    @(negedge CLK);
    foreach (tbl[j]) begin
      RESETL  = tbl[j].rstn;
      req[0]  = tbl[j].r;
      lock[0] = tbl[j].l;
      @(negedge CLK);
      check_out(0, tbl[j].exp, $sformatf("vec%0d", j));
    end

    // LOCK blocks preemption; release of LOCK preempts on the saturated cycle.
    do_reset();
    req[0]  = 3'b101;
    lock[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      check_out(0, 3'b001, "lock_hold");
    end
    lock[0] = 1'b0;
    @(negedge CLK);
    check_out(0, 3'b000, "lock_drop_gap");
    @(negedge CLK);
    check_out(0, 3'b100, "lock_drop_next");
    req[0] = 3'b000;

    // Zero turnaround: owner 0 drops, DSP takes over in the same edge.
    do_reset();
    req[1] = 3'b011;
    @(negedge CLK);
    check_out(1, 3'b001, "ta0_own");
    @(negedge CLK);
    check_out(1, 3'b001, "ta0_own2");
    req[1] = 3'b010;
    @(negedge CLK);
    check_out(1, 3'b010, "ta0_handover");
    req[1] = 3'b000;

    // Asynchronous reset between edges while BLIT owns the bus.
    do_reset();
    req[0] = 3'b100;
    @(negedge CLK);
    check_out(0, 3'b100, "pre_arst");
    #1 RESETL = 1'b0;
    #1 check_out(0, 3'b000, "arst_now");
    req[0] = 3'b110;
    #1 RESETL = 1'b1;
    @(negedge CLK);
    check_out(0, 3'b010, "post_arst_ptr");

    // Random traffic on all three instances against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NI; i++) check_out(i, model_gnt(i), "rand");
      for (int i = 0; i < NI; i++) begin
        for (int b = 0; b < 3; b++)
          if ($urandom_range(0, 3) == 0) req[i][b] = ~req[i][b];
        if ($urandom_range(0, 9) == 0) lock[i] = ~lock[i];
      end
      for (int i = 0; i < NI; i++) model_step(i, req[i], lock[i]);
      @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
